// File: rtl/stream_mem_responder.sv
// Word-addressed scratch memory that answers valid/ready requests after a fixed Latency.
// Optional requester back-pressure generator: define STREAM_MEM_RESPONDER_STALL_EN.
module stream_mem_responder #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned Latency   = 1,
   parameter logic [15:0] StallSeed = 16'hACE1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          mem_req_valid_i,
   output logic                          mem_req_ready_o,
   input  logic                          mem_req_we_i,
   input  logic [AddrWidth-1:0]          mem_req_addr_i,
   input  logic [DataWidth-1:0]          mem_req_wdata_i,
   input  logic [DataWidth/8-1:0]        mem_req_be_i,
   output logic                          mem_resp_valid_o,
   output logic [DataWidth-1:0]          mem_resp_rdata_o,
   output logic                          mem_resp_err_o,
   output logic [$clog2(Latency+1):0]    outstanding_o
);

   localparam int unsigned BeW  = DataWidth / 8;
   localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam int unsigned OutW = $clog2(Latency + 1) + 1;
   // One extra bit so NumWords itself is representable even when it equals 2**AddrWidth.
   localparam logic [AddrWidth:0] NumWordsExt = (AddrWidth + 1)'(NumWords);

   logic [DataWidth-1:0] mem_r [NumWords];
   logic                 ready_r;
   logic                 ready_s;
   logic                 accept_s;
   logic                 in_range_s;
   logic [IdxW-1:0]      idx_s;
   logic [DataWidth-1:0] rd_word_s;
   logic [DataWidth-1:0] resp_rdata_s;
   logic                 resp_err_s;

   function automatic logic [DataWidth-1:0] merge_bytes(
      input logic [DataWidth-1:0] old_word,
      input logic [DataWidth-1:0] new_word,
      input logic [BeW-1:0]       be
   );
      logic [DataWidth-1:0] merged;
      merged = old_word;
      for (int i = 0; i < BeW; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

   // Request decode and the response word produced in the accept cycle.
   always_comb begin
      in_range_s   = ({1'b0, mem_req_addr_i} < NumWordsExt);
      idx_s        = mem_req_addr_i[IdxW-1:0];
      accept_s     = mem_req_valid_i & ready_s;
      rd_word_s    = mem_r[idx_s];
      resp_rdata_s = '0;
      resp_err_s   = 1'b0;
      if (accept_s) begin
         if (!in_range_s) begin
            resp_err_s = 1'b1;
         end else if (!mem_req_we_i) begin
            resp_rdata_s = rd_word_s;
         end else begin
            resp_rdata_s = '0;
         end
      end else begin
         resp_rdata_s = '0;
         resp_err_s   = 1'b0;
      end
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk_i) begin
      if (accept_s && mem_req_we_i && in_range_s) begin
         mem_r[idx_s] <= merge_bytes(rd_word_s, mem_req_wdata_i, mem_req_be_i);
      end
   end

   // Ready stays low for one idle cycle after reset release.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= 1'b1;
      end
   end

`ifdef STREAM_MEM_RESPONDER_STALL_EN
   logic [15:0] lfsr_r;

   // Galois LFSR, x^16+x^14+x^13+x^11+1; stalls when the two low bits are both zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lfsr_r <= StallSeed;
      end else begin
         lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign ready_s = ready_r & (lfsr_r[1:0] != 2'b00);
`else
   assign ready_s = ready_r;
`endif

   assign mem_req_ready_o = ready_s;

   generate
      if (Latency == 0) begin : g_comb
         assign mem_resp_valid_o = accept_s;
         assign mem_resp_rdata_o = resp_rdata_s;
         assign mem_resp_err_o   = resp_err_s;
         assign outstanding_o    = '0;
      end else begin : g_pipe
         logic [Latency-1:0]   pipe_valid_r;
         logic [Latency-1:0]   pipe_err_r;
         logic [DataWidth-1:0] pipe_rdata_r [Latency];
         logic [OutW-1:0]      outstanding_r;

         // Non-stalling shift pipeline; idle slots carry zero data so outputs never go stale.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               pipe_valid_r <= '0;
               pipe_err_r   <= '0;
               for (int i = 0; i < Latency; i++) begin
                  pipe_rdata_r[i] <= '0;
               end
            end else begin
               pipe_valid_r[0] <= accept_s;
               pipe_err_r[0]   <= resp_err_s;
               pipe_rdata_r[0] <= resp_rdata_s;
               for (int i = 1; i < Latency; i++) begin
                  pipe_valid_r[i] <= pipe_valid_r[i-1];
                  pipe_err_r[i]   <= pipe_err_r[i-1];
                  pipe_rdata_r[i] <= pipe_rdata_r[i-1];
               end
            end
         end

         // In-flight count: +1 on accept, -1 when the last stage presents a response.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               outstanding_r <= '0;
            end else if (accept_s && !pipe_valid_r[Latency-1]) begin
               outstanding_r <= outstanding_r + OutW'(1);
            end else if (!accept_s && pipe_valid_r[Latency-1]) begin
               outstanding_r <= outstanding_r - OutW'(1);
            end else begin
               outstanding_r <= outstanding_r;
            end
         end

         assign mem_resp_valid_o = pipe_valid_r[Latency-1];
         assign mem_resp_rdata_o = pipe_rdata_r[Latency-1];
         assign mem_resp_err_o   = pipe_err_r[Latency-1];
         assign outstanding_o    = outstanding_r;
      end
   endgenerate

endmodule

// File: tb/tb_stream_mem_responder.sv
// Directed bench: three responders (Latency 1, 3, 2) share one request bus and clock.
module tb_stream_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;

   logic        rdy1, v1, e1;
   logic [31:0] d1;
   logic [1:0]  o1;
   logic        rdy3, v3, e3;
   logic [31:0] d3;
   logic [2:0]  o3;
   logic        rdy2, v2, e2;
   logic [31:0] d2;
   logic [2:0]  o2;

   int checks = 0;
   int errors = 0;
   int peak3  = 0;

   always #5 clk = ~clk;

   stream_mem_responder #(.Latency(1)) u_l1 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(req_valid), .mem_req_ready_o(rdy1),
      .mem_req_we_i(req_we), .mem_req_addr_i(req_addr), .mem_req_wdata_i(req_wdata),
      .mem_req_be_i(req_be), .mem_resp_valid_o(v1), .mem_resp_rdata_o(d1),
      .mem_resp_err_o(e1), .outstanding_o(o1)
   );

   stream_mem_responder #(.Latency(3)) u_l3 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(req_valid), .mem_req_ready_o(rdy3),
      .mem_req_we_i(req_we), .mem_req_addr_i(req_addr), .mem_req_wdata_i(req_wdata),
      .mem_req_be_i(req_be), .mem_resp_valid_o(v3), .mem_resp_rdata_o(d3),
      .mem_resp_err_o(e3), .outstanding_o(o3)
   );

   stream_mem_responder #(.Latency(2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_valid_i(req_valid), .mem_req_ready_o(rdy2),
      .mem_req_we_i(req_we), .mem_req_addr_i(req_addr), .mem_req_wdata_i(req_wdata),
      .mem_req_be_i(req_be), .mem_resp_valid_o(v2), .mem_resp_rdata_o(d2),
      .mem_resp_err_o(e2), .outstanding_o(o2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      req_be    = 4'h0;
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
   endfunction

   initial begin
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_ready", 32'(rdy1), 32'd0);
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_rdata", d1, 32'd0);
      chk("rst_err", 32'(e1), 32'd0);
      chk("rst_outstanding", 32'(o1), 32'd0);
      chk("rst_outstanding_l3", 32'(o3), 32'd0);

      rst_n = 1'b1;
      chk("ready_cycle0", 32'(rdy1), 32'd0);
      tick();
      chk("ready_cycle1", 32'(rdy1), 32'd1);
      chk("noreq_valid_c1", 32'(v1), 32'd0);
      tick();
      chk("noreq_valid_c2", 32'(v1), 32'd0);

      req(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
      tick();
      chk("wr_valid", 32'(v1), 32'd1);
      chk("wr_rdata", d1, 32'd0);
      chk("wr_err", 32'(e1), 32'd0);
      chk("wr_outstanding", 32'(o1), 32'd1);
      req(1'b0, 32'd5, 32'd0, 4'h0);
      tick();
      chk("rd_valid", 32'(v1), 32'd1);
      chk("rd_rdata", d1, 32'hDEADBEEF);
      chk("rd_err", 32'(e1), 32'd0);

      req(1'b1, 32'd5, 32'h0000_5500, 4'b0010);
      tick();
      req(1'b0, 32'd5, 32'd0, 4'h0);
      tick();
      chk("partial_rdata", d1, 32'hDEAD55EF);
      idle();
      tick();
      chk("idle_valid", 32'(v1), 32'd0);
      chk("idle_rdata", d1, 32'd0);
      chk("idle_err", 32'(e1), 32'd0);
      chk("idle_outstanding", 32'(o1), 32'd0);

      req(1'b1, 32'd0, 32'h1234_5678, 4'hF);
      tick();
      req(1'b1, 32'd1024, 32'hFFFF_FFFF, 4'hF);
      tick();
      chk("oor_wr_err", 32'(e1), 32'd1);
      chk("oor_wr_rdata", d1, 32'd0);
      req(1'b0, 32'd1024, 32'd0, 4'h0);
      tick();
      chk("oor_rd_valid", 32'(v1), 32'd1);
      chk("oor_rd_err", 32'(e1), 32'd1);
      chk("oor_rd_rdata", d1, 32'd0);
      req(1'b0, 32'h0001_0005, 32'd0, 4'h0);
      tick();
      chk("oor_high_err", 32'(e1), 32'd1);
      req(1'b0, 32'd0, 32'd0, 4'h0);
      tick();
      chk("word0_kept", d1, 32'h1234_5678);
      chk("word0_err", 32'(e1), 32'd0);

      idle();
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         req(1'b1, 32'(i), pat(i), 4'hF);
         tick();
      end
      idle();
      repeat (4) tick();
      chk("l3_drained", 32'(o3), 32'd0);

      for (int t = 0; t < 14; t++) begin
         logic        exp_v;
         int          exp_o;
         if (t < 10) req(1'b0, 32'(t), 32'd0, 4'h0);
         else idle();
         tick();
         exp_v = (t >= 2) && (t <= 11);
         exp_o = ((t + 1 < 10) ? t + 1 : 10) - ((t >= 3) ? ((t - 2 < 10) ? t - 2 : 10) : 0);
         chk($sformatf("l3_valid_t%0d", t), 32'(v3), 32'(exp_v));
         chk($sformatf("l3_rdata_t%0d", t), d3, exp_v ? pat(t - 2) : 32'd0);
         chk($sformatf("l3_outstanding_t%0d", t), 32'(o3), 32'(exp_o));
         if (int'(o3) > peak3) peak3 = int'(o3);
      end
      chk("l3_peak", 32'(peak3), 32'd3);

      idle();
      repeat (3) tick();
      req(1'b1, 32'd7, 32'hCAFE_F00D, 4'hF);
      tick();
      chk("l2_stage1_hidden", 32'(v2), 32'd0);
      chk("l2_out_after_acc1", 32'(o2), 32'd1);
      req(1'b0, 32'd7, 32'd0, 4'h0);
      rst_n = 1'b0;
      tick();
      chk("l2_rst_valid", 32'(v2), 32'd0);
      chk("l2_rst_outstanding", 32'(o2), 32'd0);
      chk("l2_rst_ready", 32'(rdy2), 32'd0);
      rst_n = 1'b1;
      idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("l2_postrst_valid_%0d", k), 32'(v2), 32'd0);
         chk($sformatf("l2_postrst_out_%0d", k), 32'(o2), 32'd0);
      end
      req(1'b0, 32'd7, 32'd0, 4'h0);
      tick();
      idle();
      tick();
      chk("l2_retained_valid", 32'(v2), 32'd1);
      chk("l2_retained_rdata", d2, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
